// File: rtl/mport_bank_loader_pkg.sv
// ---------------------------------------------------------------------------
// mport_bank_loader_pkg
// Shared constants and types for the multi-port bank loader.
//   ADDR_W  : per-bank word address width
//   DATA_W  : word width
//   NBANKS  : number of banks (fixed at four)
//   LIN_W   : linear word address width ({bank field, address field})
//   CNT_W   : job word-count width (0..65536 needs 17 bits)
//   state_t : loader FSM states
// ---------------------------------------------------------------------------
package mport_bank_loader_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int NBANKS = 4;
    localparam int BANK_W = 2;
    localparam int LIN_W  = 16;
    localparam int CNT_W  = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mport_addr_map.sv
// ---------------------------------------------------------------------------
// mport_addr_map
// Combinational translation of a linear word address into a bank select
// and a per-bank word address.
//   lin        : linear word address
//   interleave : 1 = consecutive words rotate across banks,
//                0 = each bank holds one contiguous quarter of the space
//   bank       : selected bank
//   addr       : word address inside the selected bank
// ---------------------------------------------------------------------------
module mport_addr_map
    import mport_bank_loader_pkg::*;
(
    input  logic [LIN_W-1:0]  lin,
    input  logic              interleave,
    output logic [BANK_W-1:0] bank,
    output logic [ADDR_W-1:0] addr
);

    // Interleaved mode takes the bank from the low bits so neighbouring words
    // land in different banks; contiguous mode takes it from the top bits.
    always_comb begin
        if (interleave) begin
            bank = lin[BANK_W-1:0];
            addr = lin[LIN_W-1:BANK_W];
        end else begin
            bank = lin[LIN_W-1:LIN_W-BANK_W];
            addr = lin[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/mport_bank_loader.sv
// ---------------------------------------------------------------------------
// mport_bank_loader
// Accepts a job descriptor (start address, word count, bank mapping mode),
// then streams incoming words into four independent bank write ports at one
// word per cycle. Each accepted word produces a single registered write on
// the owning bank in the following cycle.
//   clk, reset                   : clock, synchronous active-high reset
//   cfg_valid/cfg_ready          : job descriptor handshake
//   cfg_start/count/interleave   : job descriptor fields
//   abort                        : drop the job currently loading
//   in_valid/in_ready/in_data    : input word stream
//   portN_we/waddr/wdata         : registered write port for bank N
//   busy                         : job is loading
//   done                         : one-cycle pulse on normal completion
//   words_written                : words accepted in current/last job
// ---------------------------------------------------------------------------
module mport_bank_loader #(
    parameter int ADDR_W = mport_bank_loader_pkg::ADDR_W,
    parameter int DATA_W = mport_bank_loader_pkg::DATA_W,
    parameter int NBANKS = mport_bank_loader_pkg::NBANKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [15:0]       cfg_start,
    input  logic [16:0]       cfg_count,
    input  logic              cfg_interleave,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              port0_we,
    output logic [ADDR_W-1:0] port0_waddr,
    output logic [DATA_W-1:0] port0_wdata,
    output logic              port1_we,
    output logic [ADDR_W-1:0] port1_waddr,
    output logic [DATA_W-1:0] port1_wdata,
    output logic              port2_we,
    output logic [ADDR_W-1:0] port2_waddr,
    output logic [DATA_W-1:0] port2_wdata,
    output logic              port3_we,
    output logic [ADDR_W-1:0] port3_waddr,
    output logic [DATA_W-1:0] port3_wdata,
    output logic              busy,
    output logic              done,
    output logic [16:0]       words_written
);

    import mport_bank_loader_pkg::*;

    state_t              state_q, state_d;
    logic [LIN_W-1:0]    lin_q, lin_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic                interleave_q, interleave_d;
    logic [CNT_W-1:0]    words_written_q, words_written_d;
    logic [NBANKS-1:0]   we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q [NBANKS];
    logic [ADDR_W-1:0]   waddr_d [NBANKS];
    logic [DATA_W-1:0]   wdata_q [NBANKS];
    logic [DATA_W-1:0]   wdata_d [NBANKS];

    logic [BANK_W-1:0]   map_bank;
    logic [ADDR_W-1:0]   map_addr;
    logic                cfg_fire;
    logic                accept;

    mport_addr_map u_addr_map (
        .lin        (lin_q),
        .interleave (interleave_q),
        .bank       (map_bank),
        .addr       (map_addr)
    );

    // Abort masks in_ready so that no word is taken in the cycle the job is
    // being dropped.
    assign cfg_ready = (state_q == ST_IDLE);
    assign in_ready  = (state_q == ST_LOAD) && !abort;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign accept    = in_valid && in_ready;

    // Next-state and datapath update. Write strobes default low every cycle;
    // address/data registers hold their previous contents unless a word for
    // that bank is accepted.
    always_comb begin
        state_d         = state_q;
        lin_d           = lin_q;
        remaining_d     = remaining_q;
        interleave_d    = interleave_q;
        words_written_d = words_written_q;
        we_d            = '0;
        waddr_d         = waddr_q;
        wdata_d         = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_fire) begin
                    words_written_d = '0;
                    if (cfg_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        lin_d        = cfg_start;
                        remaining_d  = cfg_count;
                        interleave_d = cfg_interleave;
                        state_d      = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    we_d[map_bank]    = 1'b1;
                    waddr_d[map_bank] = map_addr;
                    wdata_d[map_bank] = in_data;
                    lin_d             = lin_q + 1'b1;
                    remaining_d       = remaining_q - 1'b1;
                    words_written_d   = words_written_q + 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register bank. Reset also clears a write strobe that would otherwise
    // appear in the cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            lin_q           <= '0;
            remaining_q     <= '0;
            interleave_q    <= 1'b0;
            words_written_q <= '0;
            we_q            <= '0;
            for (int i = 0; i < NBANKS; i++) begin
                waddr_q[i] <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            lin_q           <= lin_d;
            remaining_q     <= remaining_d;
            interleave_q    <= interleave_d;
            words_written_q <= words_written_d;
            we_q            <= we_d;
            for (int i = 0; i < NBANKS; i++) begin
                waddr_q[i] <= waddr_d[i];
                wdata_q[i] <= wdata_d[i];
            end
        end
    end

    assign busy          = (state_q == ST_LOAD);
    assign done          = (state_q == ST_DONE);
    assign words_written = words_written_q;

    assign port0_we    = we_q[0];
    assign port0_waddr = waddr_q[0];
    assign port0_wdata = wdata_q[0];
    assign port1_we    = we_q[1];
    assign port1_waddr = waddr_q[1];
    assign port1_wdata = wdata_q[1];
    assign port2_we    = we_q[2];
    assign port2_waddr = waddr_q[2];
    assign port2_wdata = wdata_q[2];
    assign port3_we    = we_q[3];
    assign port3_waddr = waddr_q[3];
    assign port3_wdata = wdata_q[3];

endmodule

// File: tb/tb_mport_bank_loader.sv
// ---------------------------------------------------------------------------
// tb_mport_bank_loader
// Self-checking bench for mport_bank_loader. Words handed to the DUT are
// translated by a reference address map into expected bank writes, queued,
// and compared when the writes appear on the bank ports.
// ---------------------------------------------------------------------------
module tb_mport_bank_loader;

    typedef struct packed {
        logic [1:0]  bank;
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_start;
    logic [16:0] cfg_count;
    logic        cfg_interleave;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        pwe    [4];
    logic [13:0] pwaddr [4];
    logic [31:0] pwdata [4];
    logic        busy;
    logic        done;
    logic [16:0] words_written;

    int          tests;
    int          fails;
    int          done_cnt;
    int          mon_n;
    wr_t         sb   [$];
    wr_t         wlog [$];
    wr_t         mon_e;
    logic [15:0] m_lin;
    logic        m_il;
    int          m_words;

    mport_bank_loader dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_start      (cfg_start),
        .cfg_count      (cfg_count),
        .cfg_interleave (cfg_interleave),
        .abort          (abort),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .port0_we       (pwe[0]),
        .port0_waddr    (pwaddr[0]),
        .port0_wdata    (pwdata[0]),
        .port1_we       (pwe[1]),
        .port1_waddr    (pwaddr[1]),
        .port1_wdata    (pwdata[1]),
        .port2_we       (pwe[2]),
        .port2_waddr    (pwaddr[2]),
        .port2_wdata    (pwdata[2]),
        .port3_we       (pwe[3]),
        .port3_waddr    (pwaddr[3]),
        .port3_wdata    (pwdata[3]),
        .busy           (busy),
        .done           (done),
        .words_written  (words_written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference address map for a word at linear address lin.
    function automatic wr_t model_map(input logic [15:0] lin, input logic il,
                                      input logic [31:0] d);
        wr_t e;
        if (il) begin
            e.bank = lin[1:0];
            e.addr = lin[15:2];
        end else begin
            e.bank = lin[15:14];
            e.addr = lin[13:0];
        end
        e.data = d;
        return e;
    endfunction

    // Write monitor: every write is logged; the scoreboard says whether a
    // write is due this cycle and which one.
    always @(negedge clk) begin
        mon_n = 0;
        for (int i = 0; i < 4; i++) begin
            if (pwe[i] === 1'b1) begin
                mon_n = mon_n + 1;
                wlog.push_back('{bank: 2'(i), addr: pwaddr[i], data: pwdata[i]});
            end
        end
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            tests = tests + 1;
            if (mon_n != 1 || pwe[mon_e.bank] !== 1'b1 ||
                pwaddr[mon_e.bank] !== mon_e.addr || pwdata[mon_e.bank] !== mon_e.data) begin
                fails = fails + 1;
                $display("[TB] FAIL write_sb: writes=%0d bank%0d we=%b addr=%h data=%h, expected one write bank%0d addr=%h data=%h",
                         mon_n, mon_e.bank, pwe[mon_e.bank], pwaddr[mon_e.bank],
                         pwdata[mon_e.bank], mon_e.bank, mon_e.addr, mon_e.data);
            end
        end else begin
            tests = tests + 1;
            if (mon_n != 0) begin
                fails = fails + 1;
                $display("[TB] FAIL spurious_write: %0d writes seen, expected 0", mon_n);
            end
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    // One input cycle: drive at the falling edge, then decide whether the
    // coming rising edge will transfer the word.
    task automatic step(input logic v, input logic [31:0] d, input logic ab,
                        input logic rst, output logic acc);
        @(negedge clk);
        cfg_valid = 1'b0;
        in_valid  = v;
        in_data   = d;
        abort     = ab;
        reset     = rst;
        #1;
        acc = v && (in_ready === 1'b1) && !rst;
        if (acc) begin
            sb.push_back(model_map(m_lin, m_il, d));
            m_lin   = m_lin + 16'd1;
            m_words = m_words + 1;
        end
    endtask

    task automatic start_job(input logic [15:0] st, input logic [16:0] cnt,
                             input logic il, output logic rdy);
        @(negedge clk);
        cfg_valid      = 1'b1;
        cfg_start      = st;
        cfg_count      = cnt;
        cfg_interleave = il;
        in_valid       = 1'b0;
        abort          = 1'b0;
        reset          = 1'b0;
        #1;
        rdy     = cfg_ready;
        m_lin   = st;
        m_il    = il;
        m_words = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests = tests + 1;
        if (busy !== 1'b0 || done !== 1'b0 || words_written !== 17'd0 ||
            cfg_ready !== 1'b1 || in_ready !== 1'b0) begin
            fails = fails + 1;
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b ww=%0d cfg_ready=%b in_ready=%b, expected 0 0 0 1 0",
                     busy, done, words_written, cfg_ready, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tests = tests + 1;
            if (pwe[i] !== 1'b0 || pwaddr[i] !== 14'd0 || pwdata[i] !== 32'd0) begin
                fails = fails + 1;
                $display("[TB] FAIL reset_port%0d: we=%b addr=%h data=%h, expected 0 0 0",
                         i, pwe[i], pwaddr[i], pwdata[i]);
            end
        end
    endtask

    task automatic test_interleave();
        logic rdy, acc;
        int   d0;
        wlog.delete();
        d0 = done_cnt;
        start_job(16'h0000, 17'd8, 1'b1, rdy);
        tests = tests + 1;
        if (rdy !== 1'b1) begin
            fails = fails + 1;
            $display("[TB] FAIL il_cfg_ready: got %b, expected 1", rdy);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'(i + 1), 1'b0, 1'b0, acc);
            tests = tests + 1;
            if (acc !== 1'b1) begin
                fails = fails + 1;
                $display("[TB] FAIL il_throughput: word %0d in_ready=%b, expected 1", i, in_ready);
            end
            if (i == 0) begin
                tests = tests + 1;
                if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
                    fails = fails + 1;
                    $display("[TB] FAIL il_busy: busy=%b cfg_ready=%b, expected 1 0", busy, cfg_ready);
                end
            end
        end
        repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, acc);
        tests = tests + 1;
        if (wlog.size() != 8) begin
            fails = fails + 1;
            $display("[TB] FAIL il_count: %0d writes, expected 8", wlog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests = tests + 1;
                if (wlog[i].bank !== 2'(i % 4) || wlog[i].addr !== 14'(i / 4) ||
                    wlog[i].data !== 32'(i + 1)) begin
                    fails = fails + 1;
                    $display("[TB] FAIL il_write%0d: bank%0d addr=%h data=%h, expected bank%0d addr=%h data=%h",
                             i, wlog[i].bank, wlog[i].addr, wlog[i].data, i % 4, i / 4, i + 1);
                end
            end
        end
        tests = tests + 1;
        if (done_cnt - d0 != 1 || words_written !== 17'd8) begin
            fails = fails + 1;
            $display("[TB] FAIL il_done: pulses=%0d ww=%0d, expected 1 8", done_cnt - d0, words_written);
        end
        tests = tests + 1;
        if (pwe[0] !== 1'b0 || pwaddr[0] !== 14'd1 || pwdata[0] !== 32'd5) begin
            fails = fails + 1;
            $display("[TB] FAIL il_hold: we=%b addr=%h data=%h, expected 0 0001 00000005",
                     pwe[0], pwaddr[0], pwdata[0]);
        end
    endtask

    task automatic test_contig_boundary();
        logic        rdy, acc;
        logic [1:0]  eb [4];
        logic [13:0] ea [4];
        eb = '{2'd0, 2'd0, 2'd1, 2'd1};
        ea = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        wlog.delete();
        start_job(16'h3FFE, 17'd4, 1'b0, rdy);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, acc);
        repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, acc);
        tests = tests + 1;
        if (wlog.size() != 4) begin
            fails = fails + 1;
            $display("[TB] FAIL contig_count: %0d writes, expected 4", wlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests = tests + 1;
                if (wlog[i].bank !== eb[i] || wlog[i].addr !== ea[i]) begin
                    fails = fails + 1;
                    $display("[TB] FAIL contig_write%0d: bank%0d addr=%h, expected bank%0d addr=%h",
                             i, wlog[i].bank, wlog[i].addr, eb[i], ea[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic rdy, acc;
        int   d0;
        wlog.delete();
        d0 = done_cnt;
        start_job(16'hFFFF, 17'd2, 1'b0, rdy);
        step(1'b1, 32'hDEAD_0001, 1'b0, 1'b0, acc);
        step(1'b1, 32'hDEAD_0002, 1'b0, 1'b0, acc);
        repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, acc);
        tests = tests + 1;
        if (wlog.size() != 2 || wlog[0].bank !== 2'd3 || wlog[0].addr !== 14'h3FFF ||
            wlog[1].bank !== 2'd0 || wlog[1].addr !== 14'h0000) begin
            fails = fails + 1;
            $display("[TB] FAIL wrap_writes: n=%0d first bank%0d addr=%h, expected 2 writes bank3 3fff then bank0 0000",
                     wlog.size(), wlog.size() > 0 ? wlog[0].bank : 2'd0,
                     wlog.size() > 0 ? wlog[0].addr : 14'd0);
        end
        tests = tests + 1;
        if (done_cnt - d0 != 1 || words_written !== 17'd2) begin
            fails = fails + 1;
            $display("[TB] FAIL wrap_done: pulses=%0d ww=%0d, expected 1 2", done_cnt - d0, words_written);
        end
    endtask

    task automatic test_zero_count();
        logic rdy, acc;
        wlog.delete();
        start_job(16'h1234, 17'd0, 1'b1, rdy);
        step(1'b1, 32'h5555_5555, 1'b0, 1'b0, acc);
        tests = tests + 1;
        if (cfg_ready !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            fails = fails + 1;
            $display("[TB] FAIL zero_done: cfg_ready=%b done=%b in_ready=%b busy=%b, expected 0 1 0 0",
                     cfg_ready, done, in_ready, busy);
        end
        step(1'b1, 32'h5555_5555, 1'b0, 1'b0, acc);
        tests = tests + 1;
        if (cfg_ready !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            fails = fails + 1;
            $display("[TB] FAIL zero_idle: cfg_ready=%b done=%b in_ready=%b, expected 1 0 0",
                     cfg_ready, done, in_ready);
        end
        step(1'b0, 32'd0, 1'b0, 1'b0, acc);
        tests = tests + 1;
        if (wlog.size() != 0 || words_written !== 17'd0) begin
            fails = fails + 1;
            $display("[TB] FAIL zero_writes: writes=%0d ww=%0d, expected 0 0", wlog.size(), words_written);
        end
    endtask

    task automatic test_abort();
        logic rdy, acc;
        int   d0;
        wlog.delete();
        d0 = done_cnt;
        start_job(16'h0100, 17'd10, 1'b0, rdy);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, acc);
        step(1'b1, 32'hBF, 1'b1, 1'b0, acc);
        tests = tests + 1;
        if (acc !== 1'b0) begin
            fails = fails + 1;
            $display("[TB] FAIL abort_ready: in_ready=%b during abort, expected 0", in_ready);
        end
        step(1'b1, 32'hC0, 1'b0, 1'b0, acc);
        tests = tests + 1;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails = fails + 1;
            $display("[TB] FAIL abort_idle: cfg_ready=%b busy=%b in_ready=%b, expected 1 0 0",
                     cfg_ready, busy, in_ready);
        end
        repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0, acc);
        tests = tests + 1;
        if (wlog.size() != 3 || done_cnt != d0 || words_written !== 17'd3) begin
            fails = fails + 1;
            $display("[TB] FAIL abort_result: writes=%0d pulses=%0d ww=%0d, expected 3 0 3",
                     wlog.size(), done_cnt - d0, words_written);
        end
    endtask

    task automatic test_reset_mid_load();
        logic rdy, acc;
        int   d0;
        int   guard;
        wlog.delete();
        d0 = done_cnt;
        guard = 0;
        start_job(16'($urandom), 17'd100, 1'b1, rdy);
        while (m_words < 50 && guard < 2000) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, acc);
            guard = guard + 1;
        end
        tests = tests + 1;
        if (m_words < 50) begin
            fails = fails + 1;
            $display("[TB] FAIL rst_timeout: %0d words accepted, expected 50", m_words);
        end
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, acc);
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, acc);
        tests = tests + 1;
        if (busy !== 1'b0 || done !== 1'b0 || words_written !== 17'd0 ||
            cfg_ready !== 1'b1 || in_ready !== 1'b0) begin
            fails = fails + 1;
            $display("[TB] FAIL rst_ctrl: busy=%b done=%b ww=%0d cfg_ready=%b in_ready=%b, expected 0 0 0 1 0",
                     busy, done, words_written, cfg_ready, in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tests = tests + 1;
            if (pwe[i] !== 1'b0 || pwaddr[i] !== 14'd0 || pwdata[i] !== 32'd0) begin
                fails = fails + 1;
                $display("[TB] FAIL rst_port%0d: we=%b addr=%h data=%h, expected 0 0 0",
                         i, pwe[i], pwaddr[i], pwdata[i]);
            end
        end
        repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0, acc);
        tests = tests + 1;
        if (wlog.size() > 50 || done_cnt != d0) begin
            fails = fails + 1;
            $display("[TB] FAIL rst_result: writes=%0d pulses=%0d, expected <=50 0",
                     wlog.size(), done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic rdy, acc;
        int   d0;
        d0 = done_cnt;
        for (int j = 0; j < 2; j++) begin
            start_job(16'h0004 + 16'(j * 16), 17'd3, 1'(j), rdy);
            tests = tests + 1;
            if (rdy !== 1'b1) begin
                fails = fails + 1;
                $display("[TB] FAIL b2b_cfg_ready: job %0d got %b, expected 1", j, rdy);
            end
            for (int i = 0; i < 3; i++) step(1'b1, 32'h7700 + 32'(j * 8 + i), 1'b0, 1'b0, acc);
            repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0, acc);
        end
        tests = tests + 1;
        if (done_cnt - d0 != 2 || words_written !== 17'd3 || sb.size() != 0) begin
            fails = fails + 1;
            $display("[TB] FAIL b2b_result: pulses=%0d ww=%0d pending=%0d, expected 2 3 0",
                     done_cnt - d0, words_written, sb.size());
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        done_cnt       = 0;
        m_lin          = 16'd0;
        m_il           = 1'b0;
        m_words        = 0;
        reset          = 1'b1;
        cfg_valid      = 1'b0;
        cfg_start      = 16'd0;
        cfg_count      = 17'd0;
        cfg_interleave = 1'b0;
        abort          = 1'b0;
        in_valid       = 1'b0;
        in_data        = 32'd0;

        test_reset();
        test_interleave();
        test_contig_boundary();
        test_wrap();
        test_zero_count();
        test_abort();
        test_reset_mid_load();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
